// File: rtl/esdi_serial_cmd_port.sv
// -----------------------------------------------------------------------------
// esdi_serial_cmd_port
//
// Drive-side ESDI serial command/status engine. It sits directly behind the
// (already polarity-corrected, active-high) ESDI serial interface pins:
//   - shifts in a 17-bit command frame (16 data bits MSB first + odd parity)
//     and presents it to drive firmware,
//   - takes a 16-bit status/config word from firmware and shifts it back to
//     the host as a 17-bit frame (odd parity bit appended last),
//   - owns esdi_command_complete (high = idle / ready for a command).
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   esdi_transfer_req          host strobe (asynchronous)
//   esdi_command_data          host serial command data (asynchronous)
//   esdi_drive_selected        drive select, decoded elsewhere (asynchronous)
//   esdi_transfer_ack          handshake acknowledge to host
//   esdi_confstat_data         serial status/config data to host
//   esdi_command_complete      high while idle
//   cmd_word/cmd_parity_err    received command and its parity verdict
//   cmd_valid/cmd_ready        command handshake towards firmware
//   resp_word/resp_valid       status word offered by firmware
//   resp_ready                 status word accepted
//   abort                      1-cycle pulse on deselect (or timeout) abort
//   dbg_state_o                current FSM state, for observation only
//
// Handshakes (cmd_valid/cmd_ready, resp_valid/resp_ready): a transfer happens
// on a rising clk edge where both valid and ready are high. cmd_valid stays
// high, with cmd_word stable, until that edge. resp_ready is only high in the
// BUSY state while resp_valid is high, so it marks exactly the transfer cycle;
// resp_valid offered earlier simply waits.
//
// Optional feature: define ESDI_CMD_TIMEOUT_EN to add a req-inactivity
// watchdog that aborts a frame after TIMEOUT_CYCLES cycles without a req edge.
// -----------------------------------------------------------------------------
module esdi_serial_cmd_port #(
  parameter int SYNC_STAGES    = 2,
  parameter int ACK_SETUP      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        esdi_transfer_req,
  input  logic        esdi_command_data,
  input  logic        esdi_drive_selected,
  output logic        esdi_transfer_ack,
  output logic        esdi_confstat_data,
  output logic        esdi_command_complete,
  output logic [15:0] cmd_word,
  output logic        cmd_parity_err,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] resp_word,
  input  logic        resp_valid,
  output logic        resp_ready,
  output logic        abort,
  output logic [3:0]  dbg_state_o
);

  localparam int SW = (ACK_SETUP < 2) ? 1 : $clog2(ACK_SETUP);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    C_SAMPLE    = 4'd1,
    C_WAIT_LOW  = 4'd2,
    C_WAIT_HIGH = 4'd3,
    C_PRESENT   = 4'd4,
    BUSY        = 4'd5,
    S_WAIT_HIGH = 4'd6,
    S_SETUP     = 4'd7,
    S_WAIT_LOW  = 4'd8
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and req edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] req_sync_q, data_sync_q, sel_sync_q;
  logic                   req_prev_q;
  logic                   req_s, data_s, sel_s, req_rise;

  // The req chain and its edge history come out of reset at 1: a req that is
  // already high when reset is released then looks like "no edge", and a
  // command can only start after req has been seen low and then high again.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_sync_q  <= '1;
      data_sync_q <= '0;
      sel_sync_q  <= '0;
      req_prev_q  <= 1'b1;
    end else begin
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], esdi_transfer_req};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], esdi_command_data};
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], esdi_drive_selected};
      req_prev_q  <= req_s;
    end
  end

  assign req_s    = req_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign sel_s    = sel_sync_q[SYNC_STAGES-1];
  assign req_rise = req_s & ~req_prev_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic            cs_q, cs_d;
  logic            cc_q, cc_d;
  logic            cv_q, cv_d;
  logic [15:0]     word_q, word_d;
  logic            perr_q, perr_d;
  logic [16:0]     shift_q, shift_d;
  logic [16:0]     rsp_q, rsp_d;
  logic [4:0]      count_q, count_d;
  logic [SW-1:0]   setup_q, setup_d;
  logic            abort_q, abort_d;
  logic            resp_ready_c;
  logic            timeout_hit;

  // ---------------------------------------------------------------------------
  // Optional req-inactivity watchdog
  // ---------------------------------------------------------------------------
`ifdef ESDI_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_q, to_d;
  logic          req_fall, to_wait, to_sat;

  assign req_fall = ~req_s & req_prev_q;
  assign to_sat   = (to_q == TW'(TIMEOUT_CYCLES));
  assign to_wait  = (state_q == C_WAIT_LOW)  || (state_q == C_WAIT_HIGH) ||
                    (state_q == S_WAIT_HIGH) || (state_q == S_WAIT_LOW);
  assign timeout_hit = to_wait & to_sat;

  // Saturates instead of wrapping so a long idle period never re-arms it.
  always_comb begin
    to_d = to_q;
    if (req_rise || req_fall || (state_d == C_PRESENT) || (state_d == BUSY)) begin
      to_d = '0;
    end else if (!to_sat) begin
      to_d = to_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  // No watchdog in this build; a negative cycle budget is the only value that
  // could ever make this true, so it folds to constant 0.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    cs_d         = cs_q;
    cc_d         = cc_q;
    cv_d         = cv_q;
    word_d       = word_q;
    perr_d       = perr_q;
    shift_d      = shift_q;
    rsp_d        = rsp_q;
    count_d      = count_q;
    setup_d      = setup_q;
    abort_d      = 1'b0;
    resp_ready_c = 1'b0;

    if ((state_q != IDLE) && (!sel_s || timeout_hit)) begin
      // Abort takes priority over everything, so no cmd_valid or resp_ready
      // can start on the abort cycle.
      ack_d   = 1'b0;
      cs_d    = 1'b0;
      cc_d    = 1'b1;
      cv_d    = 1'b0;
      count_d = 5'd0;
      abort_d = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_rise && sel_s) begin
            // Sample and acknowledge on the transition so ack follows the
            // synchronized req edge by a single cycle.
            shift_d = {shift_q[15:0], data_s};
            ack_d   = 1'b1;
            cc_d    = 1'b0;
            count_d = 5'd0;
            state_d = C_SAMPLE;
          end
        end
        C_SAMPLE: begin
          state_d = C_WAIT_LOW;
        end
        C_WAIT_LOW: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            count_d = count_q + 5'd1;
            if (count_q == 5'd16) begin
              cv_d    = 1'b1;
              word_d  = shift_q[16:1];
              perr_d  = ~(^shift_q);
              state_d = C_PRESENT;
            end else begin
              state_d = C_WAIT_HIGH;
            end
          end
        end
        C_WAIT_HIGH: begin
          if (req_rise) begin
            shift_d = {shift_q[15:0], data_s};
            ack_d   = 1'b1;
            state_d = C_SAMPLE;
          end
        end
        C_PRESENT: begin
          if (cmd_ready) begin
            cv_d    = 1'b0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          resp_ready_c = resp_valid;
          if (resp_valid) begin
            rsp_d   = {resp_word, ~(^resp_word)};
            count_d = 5'd0;
            state_d = S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (req_rise) begin
            cs_d    = rsp_q[16];
            setup_d = '0;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          if (setup_q == SW'(ACK_SETUP - 1)) begin
            ack_d   = 1'b1;
            state_d = S_WAIT_LOW;
          end else begin
            setup_d = setup_q + SW'(1);
          end
        end
        S_WAIT_LOW: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            count_d = count_q + 5'd1;
            rsp_d   = {rsp_q[15:0], 1'b0};
            if (count_q == 5'd16) begin
              cc_d    = 1'b1;
              cs_d    = 1'b0;
              count_d = 5'd0;
              state_d = IDLE;
            end else begin
              state_d = S_WAIT_HIGH;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      cs_q    <= 1'b0;
      cc_q    <= 1'b1;
      cv_q    <= 1'b0;
      word_q  <= '0;
      perr_q  <= 1'b0;
      shift_q <= '0;
      rsp_q   <= '0;
      count_q <= 5'd0;
      setup_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cs_q    <= cs_d;
      cc_q    <= cc_d;
      cv_q    <= cv_d;
      word_q  <= word_d;
      perr_q  <= perr_d;
      shift_q <= shift_d;
      rsp_q   <= rsp_d;
      count_q <= count_d;
      setup_q <= setup_d;
      abort_q <= abort_d;
    end
  end

  assign esdi_transfer_ack     = ack_q;
  assign esdi_confstat_data    = cs_q;
  assign esdi_command_complete = cc_q;
  assign cmd_word              = word_q;
  assign cmd_parity_err        = perr_q;
  assign cmd_valid             = cv_q;
  assign resp_ready            = resp_ready_c;
  assign abort                 = abort_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_esdi_serial_cmd_port.sv
// -----------------------------------------------------------------------------
// tb_esdi_serial_cmd_port
//
// Self-checking bench for esdi_serial_cmd_port. The host side of the ESDI
// serial link and the firmware side are driven from one directed initial
// block; expected command words, parity verdicts and status bit streams come
// from a small arithmetic model (popcount parity, MSB-first bit order).
// -----------------------------------------------------------------------------
module tb_esdi_serial_cmd_port;

  localparam int SYNC_STAGES    = 2;
  localparam int ACK_SETUP      = 4;
  localparam int TIMEOUT_CYCLES = 100;
  // Cycles from driving req (at a negedge) to seeing ack change at a negedge:
  // SYNC_STAGES flops, then one cycle to ack (plus ACK_SETUP in status phase).
  localparam int CMD_LAT = SYNC_STAGES + 1;
  localparam int STS_LAT = SYNC_STAGES + ACK_SETUP + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        esdi_transfer_req, esdi_command_data, esdi_drive_selected;
  logic        esdi_transfer_ack, esdi_confstat_data, esdi_command_complete;
  logic [15:0] cmd_word;
  logic        cmd_parity_err, cmd_valid, cmd_ready;
  logic [15:0] resp_word;
  logic        resp_valid, resp_ready, abort;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  esdi_serial_cmd_port #(
    .SYNC_STAGES   (SYNC_STAGES),
    .ACK_SETUP     (ACK_SETUP),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .esdi_transfer_req    (esdi_transfer_req),
    .esdi_command_data    (esdi_command_data),
    .esdi_drive_selected  (esdi_drive_selected),
    .esdi_transfer_ack    (esdi_transfer_ack),
    .esdi_confstat_data   (esdi_confstat_data),
    .esdi_command_complete(esdi_command_complete),
    .cmd_word             (cmd_word),
    .cmd_parity_err       (cmd_parity_err),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .resp_word            (resp_word),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .abort                (abort),
    .dbg_state_o          (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int cv_cnt   = 0;
  int abort_cnt = 0;
  int rr_cnt   = 0;
  logic [16:0] cmd_exp_q[$];   // {expected cmd_word, expected parity_err}
  logic [0:0]  exp_q[$];       // expected confstat bits, first bit first

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples 1ns before each rising edge, i.e. the values the DUT
  // acts on at that edge.
  always @(negedge clk) begin
    #4;
    if (reset === 1'b0) begin
      if (cmd_valid === 1'b1) cv_cnt++;
      if (abort === 1'b1) abort_cnt++;
      if (resp_valid && resp_ready === 1'b1) rr_cnt++;
      if (cmd_valid === 1'b1 && cmd_ready) begin
        if (cmd_exp_q.size() == 0) begin
          check("cmd_unexpected", 32'(cmd_valid), 32'd0);
        end else begin
          logic [16:0] e;
          e = cmd_exp_q.pop_front();
          check("cmd_word", 32'(cmd_word), 32'(e[16:1]));
          check("cmd_parity_err", 32'(cmd_parity_err), 32'(e[0]));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  function automatic logic odd_par_bit(input logic [15:0] w);
    return ($countones(w) % 2 == 0);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_ack(input logic lvl, output int cyc);
    cyc = 0;
    while (esdi_transfer_ack !== lvl && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (esdi_transfer_ack !== lvl) check("ack_wait_timeout", 32'(esdi_transfer_ack), 32'(lvl));
  endtask

  task automatic cmd_bit(input logic b, input logic chk_lat);
    int cyc;
    esdi_command_data = b;
    @(negedge clk);
    esdi_transfer_req = 1'b1;
    wait_ack(1'b1, cyc);
    if (chk_lat) check("cmd_ack_rise_lat", cyc, CMD_LAT);
    check("cc_low_during_cmd", 32'(esdi_command_complete), 32'd0);
    @(negedge clk);
    esdi_transfer_req = 1'b0;
    wait_ack(1'b0, cyc);
    if (chk_lat) check("cmd_ack_fall_lat", cyc, CMD_LAT);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [16:0] f, input int nbits);
    for (int i = 16; i > 16 - nbits; i--) cmd_bit(f[i], (i == 16));
  endtask

  task automatic send_frame(input logic [16:0] f);
    cmd_exp_q.push_back({f[16:1], ($countones(f) % 2 == 0)});
    send_bits(f, 17);
  endtask

  task automatic wait_cmd_accept();
    int cyc;
    cyc = 0;
    while (cmd_exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cmd_exp_q.size() != 0) begin
      check("cmd_accept_timeout", cmd_exp_q.size(), 0);
      cmd_exp_q.delete();
    end
  endtask

  task automatic respond(input logic [15:0] w);
    int cyc, start;
    for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
    exp_q.push_back(odd_par_bit(w));
    start      = rr_cnt;
    resp_word  = w;
    resp_valid = 1'b1;
    cyc = 0;
    while (rr_cnt == start && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("resp_ready_pulses", rr_cnt - start, 1);
    resp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic status_bit(input logic chk_lat);
    int cyc, run;
    logic prev;
    logic [0:0] e;
    esdi_transfer_req = 1'b1;
    prev = esdi_confstat_data;
    run  = 0;
    cyc  = 0;
    while (esdi_transfer_ack !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (esdi_confstat_data === prev) run++;
      else run = 1;
      prev = esdi_confstat_data;
    end
    if (esdi_transfer_ack !== 1'b1) check("sts_ack_timeout", 32'(esdi_transfer_ack), 32'd1);
    if (chk_lat) check("sts_ack_rise_lat", cyc, STS_LAT);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
    check("confstat_bit", 32'(esdi_confstat_data), 32'(e));
    check("sts_setup_stable", 32'(run >= ACK_SETUP), 32'd1);
    check("cc_low_during_sts", 32'(esdi_command_complete), 32'd0);
    @(negedge clk);
    esdi_transfer_req = 1'b0;
    wait_ack(1'b0, cyc);
    if (chk_lat) check("sts_ack_fall_lat", cyc, CMD_LAT);
    @(negedge clk);
  endtask

  task automatic status_frame();
    for (int k = 0; k < 17; k++) status_bit(k == 0);
    check("cc_high_after_status", 32'(esdi_command_complete), 32'd1);
    check("confstat_low_after_status", 32'(esdi_confstat_data), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ack", 32'(esdi_transfer_ack), 32'd0);
    check("rst_confstat", 32'(esdi_confstat_data), 32'd0);
    check("rst_cc", 32'(esdi_command_complete), 32'd1);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_word", 32'(cmd_word), 32'd0);
    check("rst_parity_err", 32'(cmd_parity_err), 32'd0);
    check("rst_resp_ready", 32'(resp_ready), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cv0, ab0, rr0, cyc;
    logic [15:0] w;
    logic [16:0] f;

    reset               = 1'b1;
    esdi_transfer_req   = 1'b1;   // high across reset release: must be ignored
    esdi_command_data   = 1'b0;
    esdi_drive_selected = 1'b1;
    cmd_ready           = 1'b1;
    resp_word           = '0;
    resp_valid          = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("req_high_at_reset_ignored_ack", 32'(esdi_transfer_ack), 32'd0);
    check("req_high_at_reset_ignored_cc", 32'(esdi_command_complete), 32'd1);
    esdi_transfer_req = 1'b0;
    repeat (5) @(negedge clk);

    // 0x1234 with correct parity, cmd_ready held high; status 0xA5A5.
    cv0 = cv_cnt;
    send_frame({16'h1234, 1'b0});
    wait_cmd_accept();
    repeat (3) @(negedge clk);
    check("cmd_valid_one_cycle", cv_cnt - cv0, 1);
    respond(16'hA5A5);
    status_frame();

    // Random frames (random parity bit) and random status words.
    for (int n = 0; n < 3; n++) begin
      w = 16'($urandom_range(0, 65535));
      f = {w, 1'($urandom_range(0, 1))};
      send_frame(f);
      wait_cmd_accept();
      respond(16'($urandom_range(0, 65535)));
      status_frame();
    end

    // 0xFFFF with parity 0 -> parity error; resp_valid offered early and
    // cmd_ready withheld for a while.
    cmd_ready  = 1'b0;
    resp_word  = 16'h3C5A;
    resp_valid = 1'b1;
    rr0 = rr_cnt;
    send_frame({16'hFFFF, 1'b0});
    repeat (10) @(negedge clk);
    check("cmd_valid_holds", 32'(cmd_valid), 32'd1);
    check("resp_ignored_before_busy", rr_cnt - rr0, 0);
    cmd_ready = 1'b1;
    wait_cmd_accept();
    respond(16'h3C5A);
    status_frame();

    // Deselect after 8 command bits, then a clean 0x0001 frame.
    cv0 = cv_cnt;
    ab0 = abort_cnt;
    send_bits({16'hBEEF, 1'b1}, 8);
    esdi_drive_selected = 1'b0;
    repeat (6) @(negedge clk);
    check("desel_abort_pulse", abort_cnt - ab0, 1);
    check("desel_ack", 32'(esdi_transfer_ack), 32'd0);
    check("desel_cc", 32'(esdi_command_complete), 32'd1);
    check("desel_no_cmd_valid", cv_cnt - cv0, 0);
    esdi_drive_selected = 1'b1;
    repeat (5) @(negedge clk);
    send_frame({16'h0001, 1'b0});
    wait_cmd_accept();
    respond(16'($urandom_range(0, 65535)));
    status_frame();

    // Host stalls after 5 command bits.
    ab0 = abort_cnt;
    send_bits({16'h5555, 1'b1}, 5);
`ifdef ESDI_CMD_TIMEOUT_EN
    cyc = 0;
    while (abort_cnt == ab0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_abort_window",
          32'(cyc >= TIMEOUT_CYCLES && cyc <= TIMEOUT_CYCLES + 10), 32'd1);
    repeat (2) @(negedge clk);
    check("timeout_abort_pulse", abort_cnt - ab0, 1);
    check("timeout_cc", 32'(esdi_command_complete), 32'd1);
`else
    cyc = 0;
    repeat (3 * TIMEOUT_CYCLES) @(negedge clk);
    check("no_timeout_abort", abort_cnt - ab0, 0);
    check("stall_still_busy_cc", 32'(esdi_command_complete), 32'd0);
    esdi_drive_selected = 1'b0;
    repeat (6) @(negedge clk);
    check("stall_desel_abort", abort_cnt - ab0, 1);
    esdi_drive_selected = 1'b1;
`endif
    repeat (5) @(negedge clk);

    // Reset during status bit 10.
    send_frame({16'h0F0F, 1'b1});
    wait_cmd_accept();
    respond(16'h8001);
    for (int k = 0; k < 10; k++) status_bit(1'b0);
    esdi_transfer_req = 1'b1;
    wait_ack(1'b1, cyc);
    rr0 = rr_cnt;
    ab0 = abort_cnt;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (8) @(negedge clk);
    check("post_reset_req_high_no_ack", 32'(esdi_transfer_ack), 32'd0);
    esdi_transfer_req = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_no_resp_ready", rr_cnt - rr0, 0);
    check("reset_no_abort", abort_cnt - ab0, 0);

    // Recovery frame after the mid-frame reset.
    send_frame({16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1))});
    wait_cmd_accept();
    respond(16'($urandom_range(0, 65535)));
    status_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
